// File: rtl/mem_responder.sv
// 32x16 synchronous data RAM served over a req/ack handshake with programmable wait states.
// Optional write protection of the low address range is compiled in with MEM_WRITE_PROTECT_EN.
module mem_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int PROT_LIMIT  = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        cap_we;
    logic [4:0]  cap_addr;
    logic [15:0] cap_wdata;
    logic        capture;
    logic        fire;
    logic        reject;
    logic [15:0] mem [32];

`ifdef MEM_WRITE_PROTECT_EN
    localparam logic [5:0] PROT_L = 6'(PROT_LIMIT);
    assign reject = cap_we && ({1'b0, cap_addr} < PROT_L);
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // WAIT holds for WAIT_CYCLES+1 cycles; the access fires on the edge where cnt has run out.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        capture = (state == IDLE) && req;
        fire    = (state == WAIT) && (cnt == 4'd0);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt <= 4'd0;
        end else if (capture) begin
            cnt <= WAIT_LOAD;
        end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (capture) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= 16'h0000;
        end else begin
            ack <= fire;
            err <= fire && reject;
            if (fire && !cap_we) begin
                rdata <= mem[cap_addr];
            end
        end
    end

    // Reset on the firing edge drops the pending write.
    always_ff @(posedge Clock) begin
        if (!Reset && fire && cap_we && !reject) begin
            mem[cap_addr] <= cap_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder: three instances (WAIT_CYCLES 0, 1, 3) against a behavioural memory model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_s   [3];
    logic        we_s    [3];
    logic [4:0]  addr_s  [3];
    logic [15:0] wdata_s [3];
    logic        ack_s   [3];
    logic [15:0] rdata_s [3];
    logic        busy_s  [3];
    logic        err_s   [3];

    logic [15:0] ref_mem [3][32];
    logic [15:0] ref_rd  [3];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(0), .PROT_LIMIT(8)) u0 (
        .Clock(clk), .Reset(rst), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
        .ack(ack_s[0]), .rdata(rdata_s[0]), .busy(busy_s[0]), .err(err_s[0]));
    mem_responder #(.WAIT_CYCLES(1), .PROT_LIMIT(8)) u1 (
        .Clock(clk), .Reset(rst), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
        .ack(ack_s[1]), .rdata(rdata_s[1]), .busy(busy_s[1]), .err(err_s[1]));
    mem_responder #(.WAIT_CYCLES(3), .PROT_LIMIT(8)) u2 (
        .Clock(clk), .Reset(rst), .req(req_s[2]), .we(we_s[2]), .addr(addr_s[2]), .wdata(wdata_s[2]),
        .ack(ack_s[2]), .rdata(rdata_s[2]), .busy(busy_s[2]), .err(err_s[2]));

    function automatic int wc(int i);
        case (i)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic bit prot_hit(bit w, logic [4:0] a);
`ifdef MEM_WRITE_PROTECT_EN
        return w && (a < 5'd8);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full handshake; ack is expected WAIT_CYCLES+1 edges after the capture edge.
    task automatic txn(int i, bit w, logic [4:0] a, logic [15:0] d, bit churn);
        int n;
        bit busy_ok;
        bit exp_err;
        req_s[i] = 1'b1; we_s[i] = w; addr_s[i] = a; wdata_s[i] = d;
        step();
        n = 0;
        busy_ok = 1'b1;
        while (ack_s[i] !== 1'b1 && n < 40) begin
            if (busy_s[i] !== 1'b1) busy_ok = 1'b0;
            if (churn) begin
                we_s[i]    = 1'($urandom);
                addr_s[i]  = 5'($urandom);
                wdata_s[i] = 16'($urandom);
            end
            step();
            n++;
        end
        req_s[i] = 1'b0;
        exp_err = prot_hit(w, a);
        if (w && !exp_err) ref_mem[i][a] = d;
        if (!w) ref_rd[i] = ref_mem[i][a];
        chk($sformatf("latency%0d", i), n, wc(i) + 1);
        chk($sformatf("busy_wait%0d", i), busy_ok, 1);
        chk($sformatf("busy_ack%0d", i), busy_s[i], 1);
        chk($sformatf("rdata%0d a=%0d", i, a), rdata_s[i], ref_rd[i]);
        chk($sformatf("err%0d a=%0d", i, a), err_s[i], exp_err);
        step();
        chk($sformatf("ack_drop%0d", i), ack_s[i], 0);
        chk($sformatf("idle%0d", i), busy_s[i], 0);
    endtask

    initial begin
        bit [3:0] pat;
        bit       stray;
        for (int i = 0; i < 3; i++) begin
            req_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = 5'd0; wdata_s[i] = 16'h0;
            ref_rd[i] = 16'h0;
            for (int a = 0; a < 32; a++) ref_mem[i][a] = 16'h0;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ack%0d", i), ack_s[i], 0);
            chk($sformatf("rst_busy%0d", i), busy_s[i], 0);
            chk($sformatf("rst_rdata%0d", i), rdata_s[i], 16'h0000);
            chk($sformatf("rst_err%0d", i), err_s[i], 0);
        end
        txn(0, 1'b0, 5'd3, 16'h0, 1'b0);
        chk("read3_zero", rdata_s[0], 16'h0000);

        txn(1, 1'b1, 5'd10, 16'hBEEF, 1'b0);
        txn(1, 1'b0, 5'd10, 16'h0, 1'b0);
        chk("beef_readback", rdata_s[1], 16'hBEEF);

        // Back-to-back with req held high: write then read of word 31.
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 5'd31; wdata_s[0] = 16'h1234;
        step();
        we_s[0] = 1'b0;
        pat = '0;
        for (int j = 0; j < 4; j++) begin
            step();
            pat[j] = ack_s[0];
        end
        req_s[0] = 1'b0;
        ref_mem[0][31] = 16'h1234;
        ref_rd[0] = 16'h1234;
        chk("b2b_ack_pattern", pat, 4'b1001);
        chk("b2b_rdata", rdata_s[0], 16'h1234);
        step();
        chk("b2b_ack_drop", ack_s[0], 0);

        // Reset while instance 2 is in its wait states.
        req_s[2] = 1'b1; we_s[2] = 1'b1; addr_s[2] = 5'd4; wdata_s[2] = 16'hAAAA;
        step();
        step();
        rst = 1'b1; req_s[2] = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) ref_rd[i] = 16'h0;
        chk("midrst_busy", busy_s[2], 0);
        stray = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (ack_s[2] !== 1'b0) stray = 1'b1;
            step();
        end
        chk("midrst_no_ack", stray, 0);
        txn(2, 1'b0, 5'd4, 16'h0, 1'b0);
        chk("midrst_dropped", rdata_s[2], 16'h0000);

        txn(2, 1'b1, 5'd20, 16'h7777, 1'b1);
        txn(2, 1'b0, 5'd20, 16'h0, 1'b1);
        chk("churn_readback", rdata_s[2], 16'h7777);

        txn(1, 1'b1, 5'd2, 16'h5555, 1'b0);
        txn(1, 1'b0, 5'd2, 16'h0, 1'b0);
        txn(1, 1'b1, 5'd8, 16'h5555, 1'b0);
        txn(1, 1'b0, 5'd8, 16'h0, 1'b0);
        chk("prot_limit_word", rdata_s[1], 16'h5555);

        for (int k = 0; k < 60; k++) begin
            int i;
            i = int'($urandom_range(0, 2));
            txn(i, 1'($urandom), 5'($urandom), 16'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
